ntt_host_sequencer: RTL and testbench
=====================================

Name: ntt_host_sequencer

Overview:
Host-side initiator for the NTT core's load/start/done protocol. It drives the core's `load_w`, `load_data`, `start` and `din` inputs, and consumes its `done` and `dout` outputs. The input image (twiddles, inverse twiddles, parameters, polynomial) comes from a synchronous-read source memory, and the transformed polynomial is written to a result memory. It replaces bench-driven loading when the NTT core is integrated into the SoC.

Parameters:
DATA_W, 32, word width (matches the NTT core's data size)
RING_DEPTH, 12, log2 of ring size; RING_SIZE = 2^RING_DEPTH
PE_DEPTH, 3, log2 of the core's PE count
W_COUNT, (((1<<(RING_DEPTH-PE_DEPTH))-1)+PE_DEPTH)<<PE_DEPTH, twiddle words per table (derived)
GAP, 5, idle cycles after each load stream
SRC_AW, 16, source address width
TIMEOUT, 2^20, maximum WAIT_DONE cycles

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
go  in  1  single-cycle request to run one full NTT
busy  out  1  high from the cycle after `go` is accepted until the return to IDLE
finished  out  1  one-cycle pulse: run completed, result written
err  out  1  sticky timeout flag; cleared by the next accepted `go`
src_rd  out  1  source read strobe
src_addr  out  SRC_AW  source word address
src_data  in  DATA_W  read data, valid exactly 1 cycle after `src_rd`
load_w  out  1  to core
load_data  out  1  to core
start  out  1  to core
din  out  DATA_W  to core
done  in  1  from core
dout  in  DATA_W  from core
res_we  out  1  result write strobe
res_addr  out  RING_DEPTH  result word address
res_data  out  DATA_W  result word

Behaviour:
- Reset (`reset` = 0, asynchronous): state IDLE; all outputs 0; `err` = 0. Asserting `reset` mid-run aborts immediately with no result writes. Deassertion is synchronised internally.
- Source layout:
  - W at 0 .. W_COUNT-1
  - WINV at W_COUNT .. 2*W_COUNT-1
  - q at 2*W_COUNT
  - n_inv at 2*W_COUNT+1
  - polynomial at 2*W_COUNT+2 .. 2*W_COUNT+1+RING_SIZE
- States: IDLE -> LDW -> WSTREAM -> GAP1 -> LDD -> DSTREAM -> GAP2 -> START -> WAIT_DONE -> CAPTURE -> FIN -> IDLE.
- IDLE: `go` = 1 moves to LDW. `go` in any other state is ignored.
- LDW (1 cycle): `load_w` = 1. `src_rd` = 1 with `src_addr` = 0 (prefetch).
- WSTREAM (2*W_COUNT+2 cycles): `din` = `src_data` registered. Word k appears in the k-th cycle after the `load_w` cycle, with no bubbles. `src_rd` runs one address ahead and stops after the last word.
- GAP1, GAP2 (GAP cycles each): `din` = 0, no strobes.
- LDD (1 cycle): `load_data` = 1, prefetch the first polynomial word.
- DSTREAM (RING_SIZE cycles): polynomial words on `din`, contiguous, same timing as WSTREAM.
- START (1 cycle): `start` = 1.
- WAIT_DONE:
  - `done` is ignored in the START cycle.
  - On the first cycle `done` = 1, go to CAPTURE.
  - If TIMEOUT cycles elapse without `done`, set `err` = 1 and go to IDLE with no `finished` pulse.
- CAPTURE (RING_SIZE cycles): the first result word is `dout` in the cycle after `done` was sampled high. Each cycle, `res_we` = 1, `res_addr` = i (0 .. RING_SIZE-1), and `res_data` = `dout` registered, one cycle later. `done` is don't-care in this state.
- FIN (1 cycle): `finished` = 1. `busy` drops the same cycle.
- `din` is 0 in every non-stream state. `load_w`, `load_data` and `start` are never asserted together and are always exactly 1 cycle wide.
- Counters are sized to hold 2*W_COUNT+2 and TIMEOUT without wrap. Address arithmetic is unsigned with no modulo.

Test Plan:
Configuration for all tests: RING_DEPTH=4, PE_DEPTH=1, GAP=5, so W_COUNT=16. Source word at address k holds k+0x100.
1. Idle after reset, `go` sampled in cycle 0 -> `load_w` high in cycle 1; `din` = 0x100 .. 0x121 in cycles 2..35; `load_data` in cycle 41; `din` = 0x122 .. 0x131 in cycles 42..57; `start` in cycle 63.
2. Core model raises `done` 20 cycles after `start`, then supplies `dout` = 0xA0+i -> 16 writes with `res_addr` 0..15 and `res_data` 0xA0..0xAF, followed by one `finished` pulse; `err` = 0.
3. Integrated with the NTT core and the known-answer vectors -> all 16 result words match the expected output.
4. `go` pulsed again during DSTREAM -> ignored; the stream is uninterrupted and exactly one `finished` pulse occurs.
5. `done` held low, TIMEOUT=64 -> `err` = 1 at 64 cycles after `start`; no `res_we`; `busy` = 0; the next `go` clears `err`.
6. `reset` asserted mid-WSTREAM -> all outputs 0 immediately (asynchronously); after release, a new `go` completes correctly from address 0.

Source files
------------

// File: rtl/ntt_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ntt_host_sequencer
//  Purpose  : Host-side initiator for the NTT core load/start/done protocol.
//             Streams twiddles, inverse twiddles, parameters and the
//             polynomial from a synchronous-read source memory into the core,
//             starts the transform, waits for done and writes the result
//             polynomial to a result memory.
//  Revision : 1.0  initial release
// ============================================================================
module ntt_host_sequencer #(
    parameter int DATA_W     = 32,
    parameter int RING_DEPTH = 12,
    parameter int PE_DEPTH   = 3,
    parameter int W_COUNT    = (((1 << (RING_DEPTH - PE_DEPTH)) - 1) + PE_DEPTH) << PE_DEPTH,
    parameter int GAP        = 5,
    parameter int SRC_AW     = 16,
    parameter int TIMEOUT    = 1 << 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    output logic                  busy,
    output logic                  finished,
    output logic                  err,
    output logic                  src_rd,
    output logic [SRC_AW-1:0]     src_addr,
    input  logic [DATA_W-1:0]     src_data,
    output logic                  load_w,
    output logic                  load_data,
    output logic                  start,
    output logic [DATA_W-1:0]     din,
    input  logic                  done,
    input  logic [DATA_W-1:0]     dout,
    output logic                  res_we,
    output logic [RING_DEPTH-1:0] res_addr,
    output logic [DATA_W-1:0]     res_data
);

    localparam int c_ring_size = 1 << RING_DEPTH;
    // Both twiddle tables plus q and n_inv travel in one load_w stream.
    localparam int c_wlen      = 2 * W_COUNT + 2;
    localparam int c_max_a     = (c_wlen > c_ring_size) ? c_wlen : c_ring_size;
    localparam int c_max_b     = (c_max_a > GAP) ? c_max_a : GAP;
    localparam int c_cnt_max   = (c_max_b > TIMEOUT) ? c_max_b : TIMEOUT;
    localparam int CNT_W       = $clog2(c_cnt_max + 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LDW       = 4'd1,
        S_WSTREAM   = 4'd2,
        S_GAP1      = 4'd3,
        S_LDD       = 4'd4,
        S_DSTREAM   = 4'd5,
        S_GAP2      = 4'd6,
        S_START     = 4'd7,
        S_WAIT_DONE = 4'd8,
        S_CAPTURE   = 4'd9,
        S_FIN       = 4'd10
    } state_t;

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_src_rd;
    logic [SRC_AW-1:0]     w_src_addr;
    logic                  w_timeout;
    logic                  r_dvalid;
    logic                  r_err;
    logic                  r_we;
    logic [RING_DEPTH-1:0] r_waddr;
    logic [DATA_W-1:0]     r_wdata;

    // Reset asserts asynchronously and releases two clocks after the pin rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // State register.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next state, source read schedule and timeout detection.
    always_comb begin
        w_next     = r_state;
        w_src_rd   = 1'b0;
        w_src_addr = '0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: if (go) w_next = S_LDW;
            S_LDW: begin
                w_src_rd = 1'b1;
                w_next   = S_WSTREAM;
            end
            S_WSTREAM: begin
                // Reads run one word ahead of din and stop at the last word.
                if (r_cnt < CNT_W'(c_wlen - 1)) begin
                    w_src_rd   = 1'b1;
                    w_src_addr = SRC_AW'(r_cnt) + SRC_AW'(1);
                end
                if (r_cnt == CNT_W'(c_wlen - 1)) w_next = S_GAP1;
            end
            S_GAP1: if (r_cnt == CNT_W'(GAP - 1)) w_next = S_LDD;
            S_LDD: begin
                w_src_rd   = 1'b1;
                w_src_addr = SRC_AW'(c_wlen);
                w_next     = S_DSTREAM;
            end
            S_DSTREAM: begin
                if (r_cnt < CNT_W'(c_ring_size - 1)) begin
                    w_src_rd   = 1'b1;
                    w_src_addr = SRC_AW'(c_wlen + 1) + SRC_AW'(r_cnt);
                end
                if (r_cnt == CNT_W'(c_ring_size - 1)) w_next = S_GAP2;
            end
            S_GAP2: if (r_cnt == CNT_W'(GAP - 1)) w_next = S_START;
            S_START: w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                // r_cnt = 0 one cycle after start, so err shows TIMEOUT cycles after start.
                if (done) begin
                    w_next = S_CAPTURE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 2)) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_CAPTURE: if (r_cnt == CNT_W'(c_ring_size - 1)) w_next = S_FIN;
            S_FIN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Phase counter, din valid flag, sticky error and registered result writes.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt    <= '0;
            r_dvalid <= 1'b0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            if ((w_next != r_state) || (r_state == S_IDLE)) r_cnt <= '0;
            else                                             r_cnt <= r_cnt + CNT_W'(1);
            r_dvalid <= w_src_rd;
            if ((r_state == S_IDLE) && go) r_err <= 1'b0;
            else if (w_timeout)            r_err <= 1'b1;
            r_we    <= (r_state == S_CAPTURE);
            r_waddr <= (r_state == S_CAPTURE) ? RING_DEPTH'(r_cnt) : '0;
            r_wdata <= (r_state == S_CAPTURE) ? dout : '0;
        end
    end

    assign busy      = (r_state != S_IDLE) && (r_state != S_FIN);
    assign finished  = (r_state == S_FIN);
    assign err       = r_err;
    assign src_rd    = w_src_rd;
    assign src_addr  = w_src_addr;
    assign load_w    = (r_state == S_LDW);
    assign load_data = (r_state == S_LDD);
    assign start     = (r_state == S_START);
    assign din       = r_dvalid ? src_data : '0;
    assign res_we    = r_we;
    assign res_addr  = r_waddr;
    assign res_data  = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ntt_host_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ntt_host_sequencer
//  Purpose  : Self-checking bench for ntt_host_sequencer with a source memory
//             model, a core model and a cycle-timeline reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ntt_host_sequencer;

    localparam int DW   = 32;
    localparam int RD   = 4;
    localparam int PD   = 1;
    localparam int GP   = 5;
    localparam int AW   = 16;
    localparam int TO   = 64;
    localparam int WC   = (((1 << (RD - PD)) - 1) + PD) << PD;
    localparam int RS   = 1 << RD;
    localparam int WLEN = 2 * WC + 2;
    localparam int MEMN = WLEN + RS;
    // Timeline relative to the go cycle (t = 0).
    localparam int T_WS  = 2;
    localparam int T_G1  = T_WS + WLEN;
    localparam int T_LDD = T_G1 + GP;
    localparam int T_DS  = T_LDD + 1;
    localparam int T_G2  = T_DS + RS;
    localparam int T_ST  = T_G2 + GP;
    localparam int LOG   = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic          busy, finished, err, src_rd, load_w, load_data, start, res_we;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_data = '0;
    logic [DW-1:0] din, dout, res_data;
    logic          done;
    logic [RD-1:0] res_addr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] mem  [0:MEMN-1];
    logic [DW-1:0] vals [0:RS-1];
    int  core_cnt  = 0;
    bit  core_act  = 1'b0;
    int  core_lat  = 20;
    int  core_hold = 1;
    bit  core_en   = 1'b1;

    logic          lg_lw [0:LOG-1];
    logic          lg_ld [0:LOG-1];
    logic          lg_st [0:LOG-1];
    logic          lg_rd [0:LOG-1];
    logic          lg_we [0:LOG-1];
    logic          lg_fin [0:LOG-1];
    logic          lg_busy [0:LOG-1];
    logic          lg_err [0:LOG-1];
    logic [DW-1:0] lg_din [0:LOG-1];
    logic [AW-1:0] lg_addr [0:LOG-1];
    logic [RD-1:0] lg_waddr [0:LOG-1];
    logic [DW-1:0] lg_wdata [0:LOG-1];

    ntt_host_sequencer #(
        .DATA_W(DW), .RING_DEPTH(RD), .PE_DEPTH(PD), .GAP(GP), .SRC_AW(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .busy(busy), .finished(finished), .err(err),
        .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
        .load_w(load_w), .load_data(load_data), .start(start), .din(din),
        .done(done), .dout(dout),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read source memory: data one cycle after the read strobe.
    always @(posedge clk) if (src_rd) src_data <= (int'(src_addr) < MEMN) ? mem[src_addr] : 32'hDEAD_BEEF;

    // Core model: done core_lat cycles after start, then one result word per cycle.
    always @(posedge clk) begin
        if (start) begin
            core_cnt <= 1;
            core_act <= 1'b1;
        end else if (core_act && core_cnt < 100000) begin
            core_cnt <= core_cnt + 1;
        end
    end
    assign done = core_en && core_act && (core_cnt >= core_lat) && (core_cnt < core_lat + core_hold);
    assign dout = (core_act && core_cnt > core_lat && core_cnt <= core_lat + RS) ?
                  vals[(core_cnt - core_lat - 1) % RS] : '0;

    // Per-cycle trace of DUT outputs, sampled away from the active edge.
    always @(negedge clk) begin
        if (cyc < LOG) begin
            lg_lw[cyc]    <= load_w;
            lg_ld[cyc]    <= load_data;
            lg_st[cyc]    <= start;
            lg_rd[cyc]    <= src_rd;
            lg_we[cyc]    <= res_we;
            lg_fin[cyc]   <= finished;
            lg_busy[cyc]  <= busy;
            lg_err[cyc]   <= err;
            lg_din[cyc]   <= din;
            lg_addr[cyc]  <= src_addr;
            lg_waddr[cyc] <= res_addr;
            lg_wdata[cyc] <= res_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference timeline derived from the phase lengths.
    function automatic logic [DW-1:0] exp_din(int t);
        if (t >= T_WS && t < T_G1) return mem[t - T_WS];
        if (t >= T_DS && t < T_G2) return mem[WLEN + t - T_DS];
        return '0;
    endfunction

    function automatic logic exp_rd(int t);
        return ((t >= 1 && t < T_G1 - 1) || (t >= T_LDD && t < T_G2 - 1));
    endfunction

    function automatic logic [AW-1:0] exp_addr(int t);
        if (t >= 1 && t < T_G1 - 1)     return AW'(t - 1);
        if (t >= T_LDD && t < T_G2 - 1) return AW'(WLEN + t - T_LDD);
        return '0;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < MEMN; k++) mem[k] = $urandom;
        for (int i = 0; i < RS; i++) vals[i] = $urandom;
    endtask

    task automatic fill_plan();
        for (int k = 0; k < MEMN; k++) mem[k] = 32'h100 + k;
        for (int i = 0; i < RS; i++) vals[i] = 32'hA0 + i;
    endtask

    // Pulse go, optionally pulse it again at cycle extra_t, wait for busy to fall.
    task automatic do_run(input int lat, input int hold, input bit en, input int extra_t,
                          output int g, output bit ok);
        core_lat  = lat;
        core_hold = hold;
        core_en   = en;
        @(negedge clk);
        go = 1'b1;
        g  = cyc;
        @(negedge clk);
        go = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            go = (extra_t > 0) && ((cyc - g) == extra_t);
            if (!busy && (cyc - g) > 1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        go = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({busy, finished, err, src_rd, load_w, load_data, start, res_we} !== 8'h00) begin
            bad++;
            $display("FAIL reset_strobes: got %b want 00000000",
                     {busy, finished, err, src_rd, load_w, load_data, start, res_we});
        end
        total++;
        if ({din, res_data, src_addr, res_addr} !== '0) begin
            bad++;
            $display("FAIL reset_buses: got din=%h res_data=%h src_addr=%h res_addr=%h want 0",
                     din, res_data, src_addr, res_addr);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({busy, err, src_rd, din} !== '0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b err=%b src_rd=%b din=%h want 0", busy, err, src_rd, din);
        end
    endtask

    task automatic test_stream();
        int g; bit ok; int c;
        fill_plan();
        do_run(20, 1, 1'b1, 0, g, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stream_end: busy=1 after budget, want 0"); end
        for (int t = 0; t <= T_ST + 1; t++) begin
            c = g + t;
            total++;
            if ({lg_lw[c], lg_ld[c], lg_st[c]} !== {1'(t == 1), 1'(t == T_LDD), 1'(t == T_ST)}) begin
                bad++;
                $display("FAIL strobes t=%0d: got lw/ld/st=%b%b%b want %b%b%b", t, lg_lw[c], lg_ld[c], lg_st[c],
                         t == 1, t == T_LDD, t == T_ST);
            end
            total++;
            if (lg_din[c] !== exp_din(t)) begin
                bad++;
                $display("FAIL din t=%0d: got %h want %h", t, lg_din[c], exp_din(t));
            end
            total++;
            if ({lg_rd[c], lg_addr[c]} !== {exp_rd(t), exp_addr(t)}) begin
                bad++;
                $display("FAIL src_rd t=%0d: got rd=%b addr=%0d want rd=%b addr=%0d", t, lg_rd[c], lg_addr[c],
                         exp_rd(t), exp_addr(t));
            end
        end
    endtask

    task automatic test_capture();
        int g; bit ok; int c; int d; logic ew; logic [RD-1:0] ea; logic [DW-1:0] ed;
        fill_plan();
        do_run(20, 1, 1'b1, 0, g, ok);
        d = T_ST + 20;
        total++;
        if (!ok) begin bad++; $display("FAIL capture_end: busy=1 after budget, want 0"); end
        for (int t = T_ST; t <= d + 20; t++) begin
            c  = g + t;
            ew = (t >= d + 2) && (t < d + 2 + RS);
            ea = ew ? RD'(t - d - 2) : '0;
            ed = ew ? vals[t - d - 2] : '0;
            total++;
            if ({lg_we[c], lg_waddr[c], lg_wdata[c]} !== {ew, ea, ed}) begin
                bad++;
                $display("FAIL write t=%0d: got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                         t, lg_we[c], lg_waddr[c], lg_wdata[c], ew, ea, ed);
            end
            total++;
            if ({lg_fin[c], lg_busy[c], lg_err[c]} !== {1'(t == d + RS + 1), 1'(t < d + RS + 1), 1'b0}) begin
                bad++;
                $display("FAIL fin_busy_err t=%0d: got %b%b%b want %b%b0", t, lg_fin[c], lg_busy[c], lg_err[c],
                         t == d + RS + 1, t < d + RS + 1);
            end
        end
    endtask

    task automatic test_random();
        int g; bit ok; int c; int d; int lat; int nwe; int nfin;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            lat = $urandom_range(1, 50);
            do_run(lat, $urandom_range(1, 20), 1'b1, 0, g, ok);
            d = T_ST + lat;
            total++;
            if (!ok) begin bad++; $display("FAIL rand_end run=%0d: busy=1 after budget, want 0", r); end
            nwe = 0;
            nfin = 0;
            for (int t = 0; t <= d + 20; t++) begin
                c = g + t;
                if (t <= T_ST) begin
                    total++;
                    if (lg_din[c] !== exp_din(t)) begin
                        bad++;
                        $display("FAIL rand_din run=%0d t=%0d: got %h want %h", r, t, lg_din[c], exp_din(t));
                    end
                end
                total++;
                if ((int'(lg_lw[c]) + int'(lg_ld[c]) + int'(lg_st[c])) > 1) begin
                    bad++;
                    $display("FAIL rand_excl run=%0d t=%0d: got lw/ld/st=%b%b%b want at most one",
                             r, t, lg_lw[c], lg_ld[c], lg_st[c]);
                end
                if (lg_we[c] === 1'b1) begin
                    total++;
                    if (t - d - 2 < 0 || t - d - 2 >= RS ||
                        {lg_waddr[c], lg_wdata[c]} !== {RD'(t - d - 2), vals[(t - d - 2 + RS) % RS]}) begin
                        bad++;
                        $display("FAIL rand_write run=%0d t=%0d: got addr=%0d data=%h want write at t=%0d..%0d",
                                 r, t, lg_waddr[c], lg_wdata[c], d + 2, d + 1 + RS);
                    end
                    nwe++;
                end
                if (lg_fin[c] === 1'b1) nfin++;
            end
            total++;
            if (nwe !== RS || nfin !== 1) begin
                bad++;
                $display("FAIL rand_counts run=%0d: got writes=%0d finished=%0d want %0d and 1", r, nwe, nfin, RS);
            end
        end
    endtask

    task automatic test_go_ignored();
        int g; bit ok; int c; int nlw; int nld; int nst; int nfin;
        fill_random();
        do_run(15, 1, 1'b1, T_DS + 3, g, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL goign_end: busy=1 after budget, want 0"); end
        nlw = 0; nld = 0; nst = 0; nfin = 0;
        for (int t = 0; t <= T_ST + 15 + 25; t++) begin
            c = g + t;
            if (t >= T_DS && t < T_G2) begin
                total++;
                if (lg_din[c] !== exp_din(t)) begin
                    bad++;
                    $display("FAIL goign_din t=%0d: got %h want %h", t, lg_din[c], exp_din(t));
                end
            end
            nlw += int'(lg_lw[c] === 1'b1);
            nld += int'(lg_ld[c] === 1'b1);
            nst += int'(lg_st[c] === 1'b1);
            nfin += int'(lg_fin[c] === 1'b1);
        end
        total++;
        if ({nlw, nld, nst, nfin} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            bad++;
            $display("FAIL goign_counts: got lw=%0d ld=%0d st=%0d fin=%0d want 1 each", nlw, nld, nst, nfin);
        end
    endtask

    task automatic test_timeout();
        int g; bit ok; int c; int nwe; int nfin;
        fill_random();
        do_run(5, 1, 1'b0, 0, g, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL to_end: busy=1 after budget, want 0"); end
        c = g + T_ST + TO;
        total++;
        if ({lg_err[c - 1], lg_err[c], lg_busy[c - 1], lg_busy[c]} !== 4'b0110) begin
            bad++;
            $display("FAIL to_edge: got err=%b%b busy=%b%b want err=01 busy=10",
                     lg_err[c - 1], lg_err[c], lg_busy[c - 1], lg_busy[c]);
        end
        nwe = 0; nfin = 0;
        for (int t = 0; t <= T_ST + TO + 3; t++) begin
            nwe  += int'(lg_we[g + t] === 1'b1);
            nfin += int'(lg_fin[g + t] === 1'b1);
        end
        total++;
        if (nwe !== 0 || nfin !== 0) begin
            bad++;
            $display("FAIL to_nowrite: got writes=%0d finished=%0d want 0 and 0", nwe, nfin);
        end
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL to_sticky: got err=%b want 1", err); end
        do_run(8, 2, 1'b1, 0, g, ok);
        total++;
        if ({lg_err[g], lg_err[g + 1]} !== 2'b10) begin
            bad++;
            $display("FAIL to_clear: got err=%b%b in cycles 0,1 want 10", lg_err[g], lg_err[g + 1]);
        end
        total++;
        if (!ok || lg_fin[g + T_ST + 8 + RS + 1] !== 1'b1) begin
            bad++;
            $display("FAIL to_rerun: got ok=%b finished=%b want 1 1", ok, lg_fin[g + T_ST + 8 + RS + 1]);
        end
    endtask

    task automatic test_reset_mid();
        int g; bit ok; int c; int d; int nwe;
        fill_random();
        core_en = 1'b1;
        @(negedge clk);
        go = 1'b1;
        g  = cyc;
        @(negedge clk);
        go = 1'b0;
        while ((cyc - g) < 10) @(negedge clk);
        total++;
        if ({busy, src_rd} !== 2'b11) begin bad++; $display("FAIL rmid_pre: got busy/rd=%b%b want 11", busy, src_rd); end
        reset = 1'b0;
        #1;
        total++;
        if (din !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rmid_async: got din=%h busy=%b want 0 0", din, busy);
        end
        total++;
        if ({finished, err, src_rd, load_w, load_data, start, res_we, src_addr, res_addr, res_data} !== '0) begin
            bad++;
            $display("FAIL rmid_outs: got rd=%b addr=%h we=%b fin=%b want all 0", src_rd, src_addr, res_we, finished);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        nwe = 0;
        for (int k = g; k < cyc; k++) nwe += int'(lg_we[k] === 1'b1);
        total++;
        if (nwe !== 0) begin bad++; $display("FAIL rmid_nowrite: got writes=%0d want 0", nwe); end
        fill_random();
        do_run(12, 1, 1'b1, 0, g, ok);
        d = T_ST + 12;
        total++;
        if (!ok) begin bad++; $display("FAIL rmid_end: busy=1 after budget, want 0"); end
        for (int t = 0; t <= T_WS + 3; t++) begin
            c = g + t;
            total++;
            if ({lg_rd[c], lg_addr[c], lg_din[c]} !== {exp_rd(t), exp_addr(t), exp_din(t)}) begin
                bad++;
                $display("FAIL rmid_restart t=%0d: got rd=%b addr=%0d din=%h want rd=%b addr=%0d din=%h",
                         t, lg_rd[c], lg_addr[c], lg_din[c], exp_rd(t), exp_addr(t), exp_din(t));
            end
        end
        for (int i = 0; i < RS; i++) begin
            c = g + d + 2 + i;
            total++;
            if ({lg_we[c], lg_waddr[c], lg_wdata[c]} !== {1'b1, RD'(i), vals[i]}) begin
                bad++;
                $display("FAIL rmid_write i=%0d: got we=%b addr=%0d data=%h want 1 %0d %h",
                         i, lg_we[c], lg_waddr[c], lg_wdata[c], i, vals[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_capture();
        test_random();
        test_go_ignored();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
